// File: rtl/spu_pkg.sv
// Shared scan-out constants, pixel type and fetch FSM states for the frame fetch path.
package spu_pkg;

    localparam int FRAME_W   = 320;
    localparam int FRAME_H   = 240;
    localparam int PIX_W     = 24;
    localparam int FB_ADDR_W = 17;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
            3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
            3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
            3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
            3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
            3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
            3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
            default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry skid FIFO that holds returned pixels while the pixel FIFO is full.
module fetch_skid_buf
    import spu_pkg::*;
#(
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/frame_fetch.sv
// Raster-order frame-buffer fetch into the pixel FIFO with read-latency absorption.
// Optional FRAME_FETCH_TEST_PATTERN_EN replaces pixel data with 8 vertical colour bars.
module frame_fetch
    import spu_pkg::*;
#(
    parameter int FRAME_W = spu_pkg::FRAME_W,
    parameter int FRAME_H = spu_pkg::FRAME_H,
    parameter int ADDR_W  = FB_ADDR_W,
    parameter int DATA_W  = PIX_W,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] fb_rd_addr,
    output logic              fb_rd_en,
    input  logic [DATA_W-1:0] fb_rd_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_W * FRAME_H - 1);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_cnt;
    logic [RD_LAT-1:0] vld_q;
    logic [1:0]        in_flight;
    logic [1:0]        skid_count;
    logic [DATA_W-1:0] skid_head;
    logic              issue, ret_valid, skid_empty, skid_push, skid_pop, direct_wr;

    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + 2'(vld_q[i]);
        end
    end

    // Outstanding reads plus buffered pixels never exceed the skid depth, so it cannot overflow.
    assign issue      = (state == FETCH) && !fifo_full && ((3'(in_flight) + 3'(skid_count)) < 3'd2);
    assign ret_valid  = vld_q[RD_LAT-1];
    assign skid_empty = (skid_count == '0);
    assign skid_pop   = !skid_empty && !fifo_full;
    assign direct_wr  = ret_valid && skid_empty && !fifo_full;
    assign skid_push  = ret_valid && !direct_wr;

    fetch_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (skid_push),
        .push_data(fb_rd_data),
        .pop      (skid_pop),
        .count    (skid_count),
        .head     (skid_head)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = FETCH;
            FETCH:   if (issue && (rd_addr == LAST_PIX) && !enable) state_nxt = DRAIN;
            DRAIN:   if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_addr <= '0;
            wr_cnt  <= '0;
            vld_q   <= '0;
        end else begin
            state <= state_nxt;
            vld_q <= RD_LAT'({vld_q, issue});
            if (issue) begin
                rd_addr <= (rd_addr == LAST_PIX) ? '0 : rd_addr + 1'b1;
            end
            if (fifo_wr_en) begin
                wr_cnt <= (wr_cnt == LAST_PIX) ? '0 : wr_cnt + 1'b1;
            end
        end
    end

`ifdef FRAME_FETCH_TEST_PATTERN_EN
    localparam int BAR_W  = FRAME_W / 8;
    localparam int BX_W   = $clog2(BAR_W + 1);

    logic [BX_W-1:0] bar_x;
    logic [2:0]      bar_idx;

    // Bar index wraps 7->0 exactly at line end, so the x position restarts every line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_x   <= '0;
            bar_idx <= '0;
        end else if (fifo_wr_en) begin
            if (bar_x == BX_W'(BAR_W - 1)) begin
                bar_x   <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_x <= bar_x + 1'b1;
            end
        end
    end

    assign fifo_din = fifo_wr_en ? DATA_W'(bar_color(bar_idx)) : '0;
`else
    assign fifo_din = fifo_wr_en ? (skid_pop ? skid_head : fb_rd_data) : '0;
`endif

    assign fifo_wr_en  = skid_pop || direct_wr;
    assign fb_rd_en    = issue;
    assign fb_rd_addr  = rd_addr;
    assign frame_start = issue && (rd_addr == '0);
    assign frame_done  = fifo_wr_en && (wr_cnt == LAST_PIX);
    assign busy        = (state != IDLE);

endmodule

// File: doc/frame_fetch.md
Name: frame_fetch

Overview:
- Scan-out fetch stage between the frame-buffer read port and the 100 MHz write side of the pixel FIFO that feeds vga_logic.
- Walks frame-buffer addresses in raster order and absorbs the RAM read latency.
- Writes every pixel into the FIFO exactly once, in order, under fifo_full backpressure.
- Frames repeat continuously while enabled; a frame is never truncated.

Parameters:
- FRAME_W, 320, pixels per line
- FRAME_H, 240, lines per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= FRAME_W*FRAME_H
- DATA_W, 24, pixel width, {R,G,B} 8 bits each
- RD_LAT, 1, frame-buffer read latency in cycles; legal values 1..2

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; high = map drawn, scan-out permitted
- fb_rd_addr  out  ADDR_W  frame-buffer read address
- fb_rd_en  out  1  read issue strobe; high = fb_rd_addr valid this cycle
- fb_rd_data  in  DATA_W  read data, valid RD_LAT cycles after fb_rd_en
- fifo_full  in  1  FIFO full flag, write-clock domain
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  DATA_W  FIFO write data
- frame_start  out  1  one-cycle pulse when address 0 is issued
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is written to the FIFO
- busy  out  1  high outside IDLE

Behaviour:
- Clock and reset:
  - Single clock clk; reset is asynchronous and active-low on rst_n.
  - On reset: all outputs 0, address 0, skid buffer empty, in-flight count 0, state IDLE.
- States:
  - IDLE -> FETCH when enable=1.
  - FETCH -> DRAIN when the last address FRAME_W*FRAME_H-1 is issued and enable=0.
  - DRAIN -> IDLE on the frame_done cycle.
- In FETCH with enable=1, the address after the last one wraps to 0 and fetching continues with no idle cycle.
- Issue rule:
  - fb_rd_en=1 iff state==FETCH, fifo_full=0 and (in_flight + skid_count) < 2.
  - Address increments on every issue.
- Return path:
  - Data arrives RD_LAT cycles after issue, tracked by a valid shift register.
  - Returned data goes straight to the FIFO iff the skid is empty and fifo_full=0; otherwise it enters the 2-entry skid buffer.
- FIFO write:
  - At most one write per cycle.
  - A non-empty skid has priority: its head is written when fifo_full=0.
  - fifo_wr_en is never asserted while fifo_full=1.
  - FIFO order equals address order with no loss and no duplication.
- Simultaneous events: a skid pop and a return-data push in the same cycle leave the count unchanged, and order is preserved.
- frame_done: asserted in the same cycle as the fifo_wr_en carrying pixel FRAME_W*FRAME_H-1.
- enable deasserted mid-frame: the current frame completes through DRAIN. enable re-asserted during DRAIN is ignored until IDLE.
- Reset mid-frame:
  - Immediate return to IDLE; in-flight and skid data are discarded.
  - The next frame starts at address 0.
- Widths: the pixel counter compares against FRAME_W*FRAME_H-1 as an ADDR_W constant. No multiply in RTL beyond the constant.

Optional Feature:
- FRAME_FETCH_TEST_PATTERN_EN
- Defined:
  - fb_rd_data is ignored.
  - fifo_din is 8 vertical colour bars, each FRAME_W/8 pixels wide, selected by an internal x counter that resets each line.
  - Bar colours, in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Timing, handshake and address issue are unchanged.
- Undefined: fifo_din carries fb_rd_data, and the x counter is not built.

Decomposition:
- Package spu_pkg:
  - FRAME_W, FRAME_H, PIX_W, FB_ADDR_W constants
  - rgb_t typedef (packed r, g, b bytes)
  - fetch_state_t enum {IDLE, FETCH, DRAIN}
- One natural sub-module, fetch_skid_buf: 2-entry FIFO with push, pop, count and head.

Test Plan:
- Reset values: hold rst_n=0 -> all outputs 0, busy=0. Release with enable=0 for 10 cycles -> no fb_rd_en.
- Streaming: RAM model data=address, fifo_full=0, enable=1 for 2 frames.
  - 153600 writes carrying values 0..76799 twice.
  - frame_start at issue of address 0 both times.
  - frame_done at writes 76800 and 153600.
- Backpressure: fifo_full=1 for 5 cycles starting at pixel 1000, then alternating 1/0 for 20 cycles.
  - Sequence stays contiguous with no gap or duplicate.
  - No write while full.
  - Skid count never exceeds 2.
- Mid-frame stop: drop enable at pixel 30000 -> writes continue to 76799, frame_done pulses, busy falls the next cycle, no further fb_rd_en.
- Reset mid-frame: assert rst_n=0 at pixel 500 with a full skid -> outputs clear asynchronously; after release, the first write carries value 0.
- FRAME_FETCH_TEST_PATTERN_EN defined -> pixels 0..39 = FFFFFF, 40..79 = FFFF00, 280..319 = 000000; pixel 320 = FFFFFF.
